// File: rtl/regfile_read_ports.sv
// rtl/regfile_read_ports.sv - dual read-port front end for the 32x64 register file; optional REGREAD_BYPASS_EN forwards a same-cycle write
module regfile_read_ports #(
  parameter int DEPTH_REGS = 32,
  parameter int WIDTH      = 64,
  parameter int ZERO_REG   = 31,
  localparam int AW        = $clog2(DEPTH_REGS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DEPTH_REGS-1:0][WIDTH-1:0] regs,
  input  logic                             wrEn,
  input  logic [AW-1:0]                    wrAddr,
  input  logic [WIDTH-1:0]                 wrData,
  input  logic                             reqValid,
  output logic                             reqReady,
  input  logic [AW-1:0]                    rdAddrA,
  input  logic [AW-1:0]                    rdAddrB,
  output logic                             respValid,
  input  logic                             respReady,
  output logic [WIDTH-1:0]                 dataA,
  output logic [WIDTH-1:0]                 dataB
);

  // S1: captured addresses waiting to be read
  logic             valid1_q, valid1_d;
  logic [AW-1:0]    addr_a1_q, addr_a1_d;
  logic [AW-1:0]    addr_b1_q, addr_b1_d;
  // S2: registered operand pair presented to execute
  logic             resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0] data_a_q, data_a_d;
  logic [WIDTH-1:0] data_b_q, data_b_d;

  logic             load2;
  logic             req_fire;
  logic [WIDTH-1:0] rd_a, rd_b;

  // S1 may advance whenever S2 is empty or retiring this cycle
  assign load2    = valid1_q && (!resp_valid_q || respReady);
  assign reqReady = !reset && (!valid1_q || load2);
  assign req_fire = reqValid && reqReady;

  // Operand resolution for the addresses leaving S1; the zero register wins over everything
  always_comb begin
    rd_a = regs[addr_a1_q];
    rd_b = regs[addr_b1_q];
`ifdef REGREAD_BYPASS_EN
    if (wrEn && (wrAddr == addr_a1_q)) rd_a = wrData;
    if (wrEn && (wrAddr == addr_b1_q)) rd_b = wrData;
`endif
    if (addr_a1_q == AW'(ZERO_REG)) rd_a = '0;
    if (addr_b1_q == AW'(ZERO_REG)) rd_b = '0;
  end

`ifndef REGREAD_BYPASS_EN
  // Snoop port is intentionally ignored when forwarding is not built in
  logic unused_snoop;
  assign unused_snoop = &{1'b0, wrEn, wrAddr, wrData};
`endif

  // Next-state for both pipeline stages; S2 data only changes on load2, so stalls freeze it
  always_comb begin
    valid1_d     = valid1_q;
    addr_a1_d    = addr_a1_q;
    addr_b1_d    = addr_b1_q;
    resp_valid_d = resp_valid_q;
    data_a_d     = data_a_q;
    data_b_d     = data_b_q;
    if (req_fire) begin
      valid1_d  = 1'b1;
      addr_a1_d = rdAddrA;
      addr_b1_d = rdAddrB;
    end else if (load2) begin
      valid1_d  = 1'b0;
    end
    if (load2) begin
      resp_valid_d = 1'b1;
      data_a_d     = rd_a;
      data_b_d     = rd_b;
    end else if (resp_valid_q && respReady) begin
      resp_valid_d = 1'b0;
    end
  end

  // Pipeline registers; reset discards anything in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid1_q     <= 1'b0;
      addr_a1_q    <= '0;
      addr_b1_q    <= '0;
      resp_valid_q <= 1'b0;
      data_a_q     <= '0;
      data_b_q     <= '0;
    end else begin
      valid1_q     <= valid1_d;
      addr_a1_q    <= addr_a1_d;
      addr_b1_q    <= addr_b1_d;
      resp_valid_q <= resp_valid_d;
      data_a_q     <= data_a_d;
      data_b_q     <= data_b_d;
    end
  end

  assign respValid = resp_valid_q;
  assign dataA     = data_a_q;
  assign dataB     = data_b_q;

endmodule

// File: tb/tb_regfile_read_ports.sv
// tb/tb_regfile_read_ports.sv - self-checking bench for regfile_read_ports against a queue model
module tb_regfile_read_ports;

  logic              clk;
  logic              reset;
  logic [31:0][63:0] regs;
  logic              wrEn;
  logic [4:0]        wrAddr;
  logic [63:0]       wrData;
  logic              reqValid;
  logic              reqReady;
  logic [4:0]        rdAddrA;
  logic [4:0]        rdAddrB;
  logic              respValid;
  logic              respReady;
  logic [63:0]       dataA;
  logic [63:0]       dataB;

  regfile_read_ports dut (
    .clk(clk), .reset(reset), .regs(regs),
    .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
    .reqValid(reqValid), .reqReady(reqReady),
    .rdAddrA(rdAddrA), .rdAddrB(rdAddrB),
    .respValid(respValid), .respReady(respReady),
    .dataA(dataA), .dataB(dataB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [4:0]  b;
    bit          res;
    logic [63:0] da;
    logic [63:0] db;
  } ent_t;

  // Outstanding requests in arrival order; res marks an operand pair already read
  ent_t q[$];
  ent_t qn[$];

  int          n_cmp = 0;
  int          n_fail = 0;
  bit          run = 0;
  bit          exp_valid, exp_ready;
  logic [63:0] exp_da, exp_db;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Operand value from the architectural rules
  function automatic logic [63:0] mread(input logic [4:0] ad);
    if (ad == 5'd31) return 64'h0;
`ifdef REGREAD_BYPASS_EN
    if (wrEn && wrAddr == ad) return wrData;
`endif
    return regs[ad];
  endfunction

  // Apply inputs for one cycle and work out what the block must show and become
  task automatic drive(input bit rv, input logic [4:0] a, input logic [4:0] b, input bit rr,
                       input bit we, input logic [4:0] wa, input logic [63:0] wd);
    bit   has_unres, adv;
    ent_t e;
    reqValid = rv; rdAddrA = a; rdAddrB = b; respReady = rr;
    wrEn = we; wrAddr = wa; wrData = wd;
    exp_valid = (q.size() > 0) && q[0].res;
    has_unres = (q.size() > 0) && !q[q.size()-1].res;
    adv       = has_unres && (!exp_valid || rr);
    exp_ready = !has_unres || adv;
    exp_da    = exp_valid ? q[0].da : 64'h0;
    exp_db    = exp_valid ? q[0].db : 64'h0;
    qn = q;
    if (adv) begin
      e = qn[qn.size()-1];
      e.res = 1'b1;
      e.da  = mread(e.a);
      e.db  = mread(e.b);
      qn[qn.size()-1] = e;
    end
    if (exp_valid && rr) void'(qn.pop_front());
    if (rv && exp_ready) begin
      e.a = a; e.b = b; e.res = 1'b0; e.da = 64'h0; e.db = 64'h0;
      qn.push_back(e);
    end
    #1;
  endtask

  // Clock edge: the bench acts as the register array and commits the write here
  task automatic tick();
    @(posedge clk);
    #1;
    q = qn;
    if (wrEn) regs[wrAddr] = wrData;
  endtask

  task automatic idle(input bit rr);
    drive(1'b0, 5'd0, 5'd0, rr, 1'b0, 5'd0, 64'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    reqValid = 1'b0; respReady = 1'b0; wrEn = 1'b0;
    #1;
    check("rst_respValid", {63'h0, respValid}, 64'h0);
    check("rst_reqReady", {63'h0, reqReady}, 64'h0);
    check("rst_dataA", dataA, 64'h0);
    q.delete();
    qn.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (run && !reset) begin
      check("respValid", {63'h0, respValid}, {63'h0, exp_valid});
      check("reqReady", {63'h0, reqReady}, {63'h0, exp_ready});
      if (exp_valid) begin
        check("dataA", dataA, exp_da);
        check("dataB", dataB, exp_db);
      end
    end
  end

  initial begin
    reset = 1'b1;
    regs = '0;
    reqValid = 1'b0; respReady = 1'b0; wrEn = 1'b0;
    wrAddr = '0; wrData = '0; rdAddrA = '0; rdAddrB = '0;
    #1;
    check("init_reqReady", {63'h0, reqReady}, 64'h0);
    check("init_respValid", {63'h0, respValid}, 64'h0);
    check("init_dataB", dataB, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    run = 1'b1;

    // Basic read, two-edge latency
    regs[3] = 64'h1F; regs[7] = 64'hAB;
    drive(1, 5'd3, 5'd7, 1, 0, 5'd0, 64'h0);
    check("s1_ready", {63'h0, reqReady}, 64'h1);
    tick();
    idle(1);
    check("s1_not_yet", {63'h0, respValid}, 64'h0);
    tick();
    idle(1);
    check("s1_valid", {63'h0, respValid}, 64'h1);
    check("s1_dataA", dataA, 64'h1F);
    check("s1_dataB", dataB, 64'hAB);
    tick();

    // Zero register ignores regs and any write to it
    regs[31] = 64'hFFFF;
    drive(1, 5'd31, 5'd31, 1, 1, 5'd31, 64'h77);
    tick();
    drive(0, 5'd0, 5'd0, 1, 1, 5'd31, 64'h1234);
    tick();
    idle(1);
    check("zero_dataA", dataA, 64'h0);
    check("zero_dataB", dataB, 64'h0);
    tick();

    // Write landing on the advance edge
    regs[5] = 64'h0;
    drive(1, 5'd5, 5'd5, 1, 0, 5'd0, 64'h0);
    tick();
    drive(0, 5'd0, 5'd0, 1, 1, 5'd5, 64'h55);
    tick();
    idle(1);
`ifdef REGREAD_BYPASS_EN
    check("byp_dataA", dataA, 64'h55);
    check("byp_dataB", dataB, 64'h55);
`else
    check("byp_dataA", dataA, 64'h0);
    check("byp_dataB", dataB, 64'h0);
`endif
    tick();
    idle(1);
    tick();

    // Back-pressure: two accepted, third stalls, first held stable
    for (int i = 1; i <= 6; i++) regs[i] = 64'h11 * i;
    drive(1, 5'd1, 5'd2, 0, 0, 5'd0, 64'h0);
    check("bp_rdy1", {63'h0, reqReady}, 64'h1);
    tick();
    drive(1, 5'd3, 5'd4, 0, 0, 5'd0, 64'h0);
    check("bp_rdy2", {63'h0, reqReady}, 64'h1);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(1, 5'd5, 5'd6, 0, 0, 5'd0, 64'h0);
      check("bp_rdy3_low", {63'h0, reqReady}, 64'h0);
      check("bp_holdA", dataA, 64'h11);
      check("bp_holdB", dataB, 64'h22);
      regs[1] = 64'hDEAD;
      tick();
    end
    drive(1, 5'd5, 5'd6, 1, 0, 5'd0, 64'h0);
    check("bp_rdy_rise", {63'h0, reqReady}, 64'h1);
    check("bp_first", dataA, 64'h11);
    tick();
    idle(1);
    check("bp_second_v", {63'h0, respValid}, 64'h1);
    check("bp_secondA", dataA, 64'h33);
    check("bp_secondB", dataB, 64'h44);
    tick();
    idle(1);
    check("bp_thirdA", dataA, 64'h55);
    check("bp_thirdB", dataB, 64'h66);
    tick();
    idle(1);
    check("bp_drained", {63'h0, respValid}, 64'h0);
    tick();

    // 32 back-to-back requests
    for (int i = 0; i < 32; i++) regs[i] = 64'(i);
    for (int i = 0; i < 32; i++) begin
      drive(1, 5'(i), 5'(i), 1, 0, 5'd0, 64'h0);
      if (i >= 2) begin
        check("b2b_valid", {63'h0, respValid}, 64'h1);
        check("b2b_data", dataA, 64'(i - 2));
      end
      tick();
    end
    idle(1);
    check("b2b_30", dataB, 64'd30);
    tick();
    idle(1);
    check("b2b_31", dataA, 64'h0);
    tick();
    idle(1);
    tick();

    // Reset while FULL
    drive(1, 5'd1, 5'd2, 0, 0, 5'd0, 64'h0);
    tick();
    drive(1, 5'd3, 5'd4, 0, 0, 5'd0, 64'h0);
    tick();
    do_reset();
    idle(1);
    check("post_rst_none", {63'h0, respValid}, 64'h0);
    tick();
    idle(1);
    check("post_rst_none2", {63'h0, respValid}, 64'h0);
    tick();
    regs[3] = 64'h1F; regs[7] = 64'hAB;
    drive(1, 5'd3, 5'd7, 1, 0, 5'd0, 64'h0);
    tick();
    idle(1);
    tick();
    idle(1);
    check("post_rst_A", dataA, 64'h1F);
    check("post_rst_B", dataB, 64'hAB);
    tick();

    // Randomized traffic with writes and occasional reset
    for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        drive(1'($urandom_range(0, 3) != 0),
              ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(24, 31)),
              ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(24, 31)),
              1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(24, 31)),
              {$urandom, $urandom});
        tick();
      end
    end

    run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
